// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, frame-buffer geometry and the RGB565 pixel type
// used by the scan-out engine.
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned FB_WIDTH  = 320;
  localparam int unsigned FB_HEIGHT = 240;
  localparam int unsigned VRAM_AW   = 17;
  localparam int unsigned CNT_W     = 10;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Beam position counters plus the stage-0 decode of visible region, syncs,
// blanking and the frame-start marker.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] vcnt,
  output logic [CNT_W-1:0] hcnt_next_c,
  output logic             h_wrap_c,
  output logic             v_wrap_c,
  output logic             active_c,
  output logic             hsync_c,
  output logic             vsync_c,
  output logic             vblank_c,
  output logic             frame_start_c
);

  localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VT - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt_next;

  // Next beam position; both counters wrap together at the frame end.
  always_comb begin
    h_wrap_c    = (hcnt == H_LAST);
    v_wrap_c    = h_wrap_c && (vcnt == V_LAST);
    hcnt_next_c = h_wrap_c ? '0 : hcnt + CNT_ONE;
    vcnt_next   = vcnt;
    if (v_wrap_c) begin
      vcnt_next = '0;
    end else if (h_wrap_c) begin
      vcnt_next = vcnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      hcnt <= hcnt_next_c;
      vcnt <= vcnt_next;
    end
  end

  // Stage-0 decode of the current beam position.
  always_comb begin
    active_c      = (hcnt < H_ACT) && (vcnt < V_ACT);
    hsync_c       = !((hcnt >= HS_BEG) && (hcnt <= HS_END));
    vsync_c       = !((vcnt >= VS_BEG) && (vcnt <= VS_END));
    vblank_c      = (vcnt >= V_ACT);
    frame_start_c = (hcnt == '0) && (vcnt == '0);
  end

endmodule

// File: rtl/vram_scanout.sv
// Scan-out engine: reads the 320x240 RGB565 frame buffer in step with a
// 640x480 VGA beam, doubling each pixel, with all outputs aligned at 2 clks.
module vram_scanout #(
  parameter int unsigned H_ACTIVE = vga_timing_pkg::DEF_H_ACTIVE,
  parameter int unsigned H_FP     = vga_timing_pkg::DEF_H_FP,
  parameter int unsigned H_SYNC   = vga_timing_pkg::DEF_H_SYNC,
  parameter int unsigned H_BP     = vga_timing_pkg::DEF_H_BP,
  parameter int unsigned V_ACTIVE = vga_timing_pkg::DEF_V_ACTIVE,
  parameter int unsigned V_FP     = vga_timing_pkg::DEF_V_FP,
  parameter int unsigned V_SYNC   = vga_timing_pkg::DEF_V_SYNC,
  parameter int unsigned V_BP     = vga_timing_pkg::DEF_V_BP,
  parameter int unsigned FB_WIDTH = vga_timing_pkg::FB_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst_n,
  output logic [vga_timing_pkg::VRAM_AW-1:0] vram_addr,
  input  logic [15:0]                        vram_rdata,
  output logic [4:0]                         vga_r,
  output logic [5:0]                         vga_g,
  output logic [4:0]                         vga_b,
  output logic                               vga_hsync,
  output logic                               vga_vsync,
  output logic                               vga_de,
  output logic                               vblank,
  output logic                               frame_start
);

  import vga_timing_pkg::*;

  localparam logic [VRAM_AW-1:0] ROW_STEP      = VRAM_AW'(FB_WIDTH);
  localparam logic [CNT_W-1:0]   LAST_ROW_LINE = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0]   H_ACT         = CNT_W'(H_ACTIVE);

  logic [CNT_W-1:0]   vcnt;
  logic [CNT_W-1:0]   hcnt_next_c;
  logic               h_wrap_c;
  logic               v_wrap_c;
  logic               active_c;
  logic               hsync_c;
  logic               vsync_c;
  logic               vblank_c;
  logic               frame_start_c;

  logic [VRAM_AW-1:0] line_base;
  logic [VRAM_AW-1:0] line_base_next;
  logic [VRAM_AW-1:0] addr_next;

  logic               de_s1;
  logic               hsync_s1;
  logic               vsync_s1;
  logic               vblank_s1;
  logic               frame_start_s1;
  rgb565_t            pix;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk           (clk),
    .rst_n         (rst_n),
    .vcnt          (vcnt),
    .hcnt_next_c   (hcnt_next_c),
    .h_wrap_c      (h_wrap_c),
    .v_wrap_c      (v_wrap_c),
    .active_c      (active_c),
    .hsync_c       (hsync_c),
    .vsync_c       (vsync_c),
    .vblank_c      (vblank_c),
    .frame_start_c (frame_start_c)
  );

  // Row base advances after each odd line and freezes on the last visible
  // row, so blanking lines never address past the end of the frame buffer.
  // The address is registered from the next beam position, so it always
  // corresponds to the counters currently held.
  always_comb begin
    line_base_next = line_base;
    if (v_wrap_c) begin
      line_base_next = '0;
    end else if (h_wrap_c && vcnt[0] && (vcnt < LAST_ROW_LINE)) begin
      line_base_next = line_base + ROW_STEP;
    end
    addr_next = line_base_next;
    if (hcnt_next_c < H_ACT) begin
      addr_next = line_base_next + VRAM_AW'(hcnt_next_c >> 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_base <= '0;
      vram_addr <= '0;
    end else begin
      line_base <= line_base_next;
      vram_addr <= addr_next;
    end
  end

  assign pix = rgb565_t'(vram_rdata);

  // Stage 1 holds control terms while VRAM returns data; stage 2 drives pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_s1          <= 1'b0;
      hsync_s1       <= 1'b1;
      vsync_s1       <= 1'b1;
      vblank_s1      <= 1'b0;
      frame_start_s1 <= 1'b0;
      vga_r          <= '0;
      vga_g          <= '0;
      vga_b          <= '0;
      vga_hsync      <= 1'b1;
      vga_vsync      <= 1'b1;
      vga_de         <= 1'b0;
      vblank         <= 1'b0;
      frame_start    <= 1'b0;
    end else begin
      de_s1          <= active_c;
      hsync_s1       <= hsync_c;
      vsync_s1       <= vsync_c;
      vblank_s1      <= vblank_c;
      frame_start_s1 <= frame_start_c;
      vga_r          <= de_s1 ? pix.r : '0;
      vga_g          <= de_s1 ? pix.g : '0;
      vga_b          <= de_s1 ? pix.b : '0;
      vga_hsync      <= hsync_s1;
      vga_vsync      <= vsync_s1;
      vga_de         <= de_s1;
      vblank         <= vblank_s1;
      frame_start    <= frame_start_s1;
    end
  end

endmodule

// File: tb/tb_vram_scanout.sv
// Bench for vram_scanout: a full-size instance for line-level timing and
// addressing, and a shrunken-timing instance for whole-frame behaviour.
module tb_vram_scanout;

  typedef struct packed {
    int unsigned ha, hf, hs, hb, va, vf, vs, vb;
  } tim_t;

  typedef struct packed {
    logic [16:0] addr;
    logic [15:0] pix;
    logic        hs, vs, de, vb, fs;
  } exp_t;

  localparam tim_t TA = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam tim_t TB = '{64, 4, 8, 4, 48, 2, 2, 3};

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        fill, fill_q1, fill_q2;
  logic        timeout;
  logic [15:0] mem [0:76799];

  logic [16:0] addr_a, addr_b;
  logic [15:0] rdata_a, rdata_b;
  logic [4:0]  r_a, b_a, r_b, b_b;
  logic [5:0]  g_a, g_b;
  logic        hs_a, vs_a, de_a, vb_a, fs_a;
  logic        hs_b, vs_b, de_b, vb_b, fs_b;

  int unsigned t_a, t_b;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          vs_run = 0;
  int          vb_run = 0;
  int          last_fs = -1;

  always #5 clk = ~clk;

  vram_scanout dut_a (
    .clk(clk), .rst_n(rst_a), .vram_addr(addr_a), .vram_rdata(rdata_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .vga_hsync(hs_a), .vga_vsync(vs_a),
    .vga_de(de_a), .vblank(vb_a), .frame_start(fs_a)
  );

  vram_scanout #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3), .FB_WIDTH(32)
  ) dut_b (
    .clk(clk), .rst_n(rst_b), .vram_addr(addr_b), .vram_rdata(rdata_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .vga_hsync(hs_b), .vga_vsync(vs_b),
    .vga_de(de_b), .vblank(vb_b), .frame_start(fs_b)
  );

  // VRAM read ports with one clock of latency
  always @(posedge clk) begin
    rdata_a <= (addr_a < 17'd76800) ? mem[addr_a] : 16'h0BAD;
    rdata_b <= fill ? 16'hFFFF : ((addr_b < 17'd76800) ? mem[addr_b] : 16'h0BAD);
    fill_q1 <= fill;
    fill_q2 <= fill_q1;
  end

  // clocks elapsed since each reset release
  always @(posedge clk or negedge rst_a)
    if (!rst_a) t_a <= 0; else t_a <= t_a + 1;
  always @(posedge clk or negedge rst_b)
    if (!rst_b) t_b <= 0; else t_b <= t_b + 1;

  function automatic logic [16:0] addr_of(input tim_t tm, input int unsigned t);
    int unsigned ht = tm.ha + tm.hf + tm.hs + tm.hb;
    int unsigned vt = tm.va + tm.vf + tm.vs + tm.vb;
    int unsigned h = t % ht;
    int unsigned v = (t / ht) % vt;
    int unsigned row = ((v < tm.va) ? v : tm.va - 1) / 2;
    return 17'(row * (tm.ha / 2) + ((h < tm.ha) ? h / 2 : 0));
  endfunction

  function automatic exp_t model(input tim_t tm, input int unsigned t, input logic fl);
    exp_t e;
    int unsigned ht = tm.ha + tm.hf + tm.hs + tm.hb;
    int unsigned vt = tm.va + tm.vf + tm.vs + tm.vb;
    int unsigned c, h, v;
    e.addr = addr_of(tm, t);
    e.pix = 16'h0; e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0; e.vb = 1'b0; e.fs = 1'b0;
    if (t >= 2) begin
      c = t - 2;
      h = c % ht;
      v = (c / ht) % vt;
      e.de = (h < tm.ha) && (v < tm.va);
      e.hs = !((h >= tm.ha + tm.hf) && (h < tm.ha + tm.hf + tm.hs));
      e.vs = !((v >= tm.va + tm.vf) && (v < tm.va + tm.vf + tm.vs));
      e.vb = (v >= tm.va);
      e.fs = (h == 0) && (v == 0);
      if (e.de) e.pix = fl ? 16'hFFFF : mem[addr_of(tm, c)];
    end
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d cycle=%0d", nm, act, req, cyc);
    end
  endtask

  task automatic chk_inst(input string tag, input exp_t e, input logic [16:0] ad,
                          input logic [15:0] px, input logic hs, input logic vs,
                          input logic de, input logic vb, input logic fs);
    chk({tag, "_addr"}, int'(ad), int'(e.addr));
    chk({tag, "_rgb"}, int'(px), int'(e.pix));
    chk({tag, "_hsync"}, int'(hs), int'(e.hs));
    chk({tag, "_vsync"}, int'(vs), int'(e.vs));
    chk({tag, "_de"}, int'(de), int'(e.de));
    chk({tag, "_vblank"}, int'(vb), int'(e.vb));
    chk({tag, "_fstart"}, int'(fs), int'(e.fs));
    chk({tag, "_blank_rgb"}, int'(!de && (px != 16'h0)), 0);
  endtask

  always @(negedge clk) begin
    exp_t ea, eb;
    cyc++;
    ea = model(TA, t_a, 1'b0);
    eb = model(TB, t_b, fill_q2);
    chk_inst("A", ea, addr_a, {r_a, g_a, b_a}, hs_a, vs_a, de_a, vb_a, fs_a);
    chk_inst("B", eb, addr_b, {r_b, g_b, b_b}, hs_b, vs_b, de_b, vb_b, fs_b);
    chk("A_addr_range", int'(addr_a <= 17'd76799), 1);
    chk("B_addr_range", int'(addr_b <= 17'd767), 1);
    chk("wait_timeout", int'(timeout), 0);

    // hand-computed anchors for the full-size timing
    if (!rst_a) begin
      chk("A_rst_hsync", int'(hs_a), 1);
      chk("A_rst_de", int'(de_a), 0);
      chk("A_rst_addr", int'(addr_a), 0);
    end else begin
      case (t_a)
        1:    chk("A_de_before", int'(de_a), 0);
        2:    begin
                chk("A_de_rise", int'(de_a), 1);
                chk("A_px0_r", int'(r_a), 31);
                chk("A_px0_g", int'(g_a), 0);
                chk("A_px0_b", int'(b_a), 0);
                chk("A_addr_h2", int'(addr_a), 1);
              end
        3:    chk("A_px1_r", int'(r_a), 31);
        4:    begin
                chk("A_px2_r", int'(r_a), 0);
                chk("A_px2_g", int'(g_a), 63);
              end
        5:    chk("A_px3_g", int'(g_a), 63);
        638:  chk("A_addr_h638", int'(addr_a), 319);
        639:  chk("A_addr_h639", int'(addr_a), 319);
        641:  chk("A_de_last", int'(de_a), 1);
        642:  chk("A_de_fall", int'(de_a), 0);
        657:  chk("A_hs_pre", int'(hs_a), 1);
        658:  chk("A_hs_low_first", int'(hs_a), 0);
        753:  chk("A_hs_low_last", int'(hs_a), 0);
        754:  chk("A_hs_post", int'(hs_a), 1);
        800:  chk("A_line1_base", int'(addr_a), 0);
        1600: chk("A_line2_base", int'(addr_a), 320);
        default: ;
      endcase
    end

    // whole-frame anchors for the shrunken timing (80 x 55 clks)
    if (!rst_b) begin
      vs_run = 0; vb_run = 0; last_fs = -1;
      chk("B_rst_vsync", int'(vs_b), 1);
      chk("B_rst_fstart", int'(fs_b), 0);
    end else begin
      if (!vs_b) vs_run++;
      else if (vs_run != 0) begin chk("B_vsync_len", vs_run, 160); vs_run = 0; end
      if (vb_b) vb_run++;
      else if (vb_run != 0) begin chk("B_vblank_len", vb_run, 560); vb_run = 0; end
      if (fs_b) begin
        if (last_fs >= 0) chk("B_frame_period", cyc - last_fs, 4400);
        last_fs = cyc;
      end
    end
  end

  task automatic wait_a(input int unsigned target, input int budget);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (t_a < target && n < budget);
    if (t_a < target) timeout = 1'b1;
  endtask

  task automatic wait_b(input int unsigned target, input int budget);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (t_b < target && n < budget);
    if (t_b < target) timeout = 1'b1;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; fill = 1'b0; timeout = 1'b0;
    for (int i = 0; i < 76800; i++) mem[i] = 16'($urandom);
    mem[0] = 16'hF800;
    mem[1] = 16'h07E0;
    #1 rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_a = 1'b1; rst_b = 1'b1;

    // mid-scan reset of the full-size instance at hcnt=300, line 2
    wait_a(1900, 3000);
    #1 rst_a = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_a = 1'b1;
    wait_a(2500, 3000);

    // one frame of all-ones VRAM data on the shrunken instance
    wait_b(4500, 10000);
    fill = 1'b1;
    wait_b(8900, 10000);
    fill = 1'b0;

    // mid-scan reset of the shrunken instance at hcnt=30, line 20
    wait_b(8800 + 1630, 5000);
    #1 rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_b = 1'b1;
    wait_b(4500, 6000);

    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_scanout.md
# vram_scanout

Display scan-out engine that sits directly downstream of the dual-port frame-buffer VRAM. It owns the VRAM's second port as a read-only client, generates 640×480@60 VGA timing, and fetches each 320×240 RGB565 frame-buffer pixel in step with the beam. It shows each fetched pixel as a 2×2 block and drives registered, mutually aligned RGB, sync and data-enable outputs to the display DAC/encoder.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- FB_WIDTH, 320, frame-buffer pixels per row; must equal H_ACTIVE/2

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  pixel clock, 25.175 MHz nominal
- rst_n  in  1  asynchronous active-low reset
- vram_addr  out  17  read address to the VRAM second port
- vram_rdata  in  16  VRAM read data, RGB565, registered one clk after vram_addr
- vga_r  out  5  red
- vga_g  out  6  green
- vga_b  out  5  blue
- vga_hsync  out  1  horizontal sync, active low
- vga_vsync  out  1  vertical sync, active low
- vga_de  out  1  data enable, high during the visible region
- vblank  out  1  high while the output line is at or beyond V_ACTIVE
- frame_start  out  1  one-clk pulse on the first output pixel of each frame

## Operation
- Counters: hcnt runs 0..H_TOTAL-1, where H_TOTAL = 800. vcnt runs 0..V_TOTAL-1, where V_TOTAL = 525.
  - vcnt increments when hcnt wraps.
  - Both counters wrap to 0 together at (799, 524).
- Stage 0 (counters): computes active = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
  - vram_addr = line_base + hcnt[9:1].
  - line_base is an accumulator; no multiplier is used.
    - It adds FB_WIDTH at the hcnt wrap when vcnt[0] = 1.
    - It clears to 0 at the vcnt wrap.
  - Resulting range: 0..76799. Row 239 base is 76480.
  - Outside the active region, vram_addr = line_base + (hcnt < H_ACTIVE ? hcnt[9:1] : 0). The result is never above 76799.
- Stage 1: VRAM returns the data. The sync, de, vblank and frame_start terms are delayed one register to stay aligned.
- Stage 2 (output registers):
  - RGB565 splits as r = d[15:11], g = d[10:5], b = d[4:0].
  - RGB is forced to 0 when the delayed de is 0.
- Sync and status terms, all decoded from the counters:
  - hsync low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656, 751].
  - vsync low for vcnt in [490, 491].
  - vblank = (vcnt >= 480).
  - frame_start = (hcnt == 0 && vcnt == 0).
- This block never writes VRAM. The top level ties the second port's writeEnable low and its data-in to 0.

## Timing
- Every output is a register.
- Output latency is exactly 2 clks from counter state to pins, identical for RGB, syncs, de, vblank and frame_start.
- Reset values (asserted immediately, asynchronously):
  - counters = 0, line_base = 0, vram_addr = 0
  - vga_r/g/b = 0, vga_de = 0
  - vga_hsync = 1, vga_vsync = 1
  - vblank = 0, frame_start = 0
  - all pipeline registers = 0, with sync stages = 1
- After rst_n deasserts, the first rising edge moves hcnt to 1. The counter value at cycle n is therefore n mod 800 for the first line.
- Frame period is 420000 clks. The frame_start pulse width is exactly 1 clk.
- Reset mid-frame: outputs return to reset values without a clock edge. Scan restarts at (0,0) and the pipeline refills, so no stale VRAM data is shown.
- vram_rdata is ignored whenever the delayed de = 0.

## Structure
- Shared package vga_timing_pkg holds:
  - the default timing constants
  - the derived H_TOTAL and V_TOTAL
  - FB_WIDTH and FB_HEIGHT = 240
  - VRAM_AW = 17
  - an rgb565 struct typedef (r5/g6/b5)
- One sub-module, vga_timing_gen: hcnt/vcnt counters plus stage-0 decode of active, hsync, vsync, vblank and frame_start.
- The vram_scanout top holds the line_base accumulator, the address generator, and the 2-stage alignment pipeline.

## Test plan
- Reset release: vga_de first rises at cycle 2 and falls after cycle 641. vga_hsync is low for cycles 658..753 of line 0. All outputs hold reset values while rst_n = 0.
- Address sequence: vram_addr = 0 at hcnt 0,1; 1 at 2,3; 319 at 638,639. Lines 0 and 1 use base 0, line 2 uses 320, line 479 uses 76480. The last active address is 76799, and nothing above 76799 ever appears.
- Data path: the VRAM model returns mem[a] with 1-clk latency, preloaded with mem[0] = 0xF800 and mem[1] = 0x07E0.
  - First two output pixels: r=31, g=0, b=0.
  - Next two: r=0, g=63, b=0.
- Blanking: the VRAM model drives 0xFFFF constantly. RGB = 0 on every clk where vga_de = 0, including the porches and lines 480..524.
- Frame timing: vga_vsync is low for exactly 1600 clks, covering lines 490–491. vblank is high for 45 lines. frame_start pulses are 420000 clks apart, each 1 clk wide.
- Async reset mid-scan: drop rst_n at hcnt=300, vcnt=100 between clock edges. Outputs go to reset values before the next edge. After release, the scan restarts at (0,0) and line 2's first address is 320.
